// File: rtl/rs_pkg.sv
// Shared types and helpers for the ADD-ALU reservation station.
// Holds the entry layout and the wrap-safe program-order comparison.
package rs_pkg;

   localparam int PHY_W  = 8;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic              busy;
      logic [DATA_W-1:0] pc;
      logic [3:0]        aluop;
      logic              src1;
      logic              src2;
      logic [PHY_W-1:0]  rd_phy;
      logic [PHY_W-1:0]  op1_phy;
      logic              op1_valid;
      logic [DATA_W-1:0] op1_data;
      logic [PHY_W-1:0]  op2_phy;
      logic              op2_valid;
      logic [DATA_W-1:0] op2_data;
      logic [DATA_W-1:0] imm;
      logic [31:0]       inst_num;
   } rs_entry_t;

   // a is older than b when (a - b) is negative as a signed 32-bit value.
   function automatic logic is_older(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] diff;
      diff = a - b;
      return diff[31];
   endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Combinational oldest-entry picker: returns one-hot and binary index of the
// eligible entry with the smallest (wrap-safe) program-order number.
module rs_oldest_select
   import rs_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic [DEPTH-1:0]         i_elig,
   input  logic [DEPTH-1:0][31:0]   i_inst_num,
   output logic [DEPTH-1:0]         o_onehot,
   output logic [$clog2(DEPTH)-1:0] o_idx,
   output logic                     o_any
);

   localparam int IDX_W = $clog2(DEPTH);

   // An entry wins only if it is older than every other eligible entry.
   always_comb begin
      o_onehot = '0;
      for (int i = 0; i < DEPTH; i++) begin
         o_onehot[i] = i_elig[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (j != i && i_elig[j] && !is_older(i_inst_num[i], i_inst_num[j])) begin
               o_onehot[i] = 1'b0;
            end
         end
      end
   end

   // Encode the one-hot winner into an index.
   always_comb begin
      o_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (o_onehot[i]) begin
            o_idx = o_idx | IDX_W'(i);
         end
      end
   end

   assign o_any = |i_elig;

endmodule

// File: rtl/alu_reservation_station.sv
// ADD-ALU reservation station: accepts dispatched instructions, wakes operands
// from the CDB, and issues the oldest ready entry through a one-stage issue register.
module alu_reservation_station #(
   parameter int DEPTH  = 8,
   parameter int PHY_W  = rs_pkg::PHY_W,
   parameter int DATA_W = rs_pkg::DATA_W,
   parameter int CDB_N  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    add_rs_on,
   input  logic [31:0]             add_alu_pc,
   input  logic [3:0]              out_add_ALUOP,
   input  logic                    out_add_ALUSrc1,
   input  logic                    out_add_ALUSrc2,
   input  logic [PHY_W-1:0]        add_rd_phy_reg,
   input  logic [PHY_W-1:0]        out_add_Operand1_phy,
   input  logic [PHY_W-1:0]        out_add_Operand2_phy,
   input  logic [1:0]              out_add_valid,
   input  logic [DATA_W-1:0]       disp_op1_data,
   input  logic [DATA_W-1:0]       disp_op2_data,
   input  logic [DATA_W-1:0]       out_add_immediate,
   input  logic [31:0]             out_add_inst_num,
   input  logic [CDB_N-1:0]        cdb_valid,
   input  logic [CDB_N*PHY_W-1:0]  cdb_phy,
   input  logic [CDB_N*DATA_W-1:0] cdb_data,
   input  logic                    flush,
   output logic                    rs_full,
   output logic                    rs_overflow,
   output logic                    iss_valid,
   input  logic                    alu_ready,
   output logic [DATA_W-1:0]       iss_pc,
   output logic [DATA_W-1:0]       iss_op1,
   output logic [DATA_W-1:0]       iss_op2,
   output logic [DATA_W-1:0]       iss_imm,
   output logic [3:0]              iss_aluop,
   output logic                    iss_src1,
   output logic                    iss_src2,
   output logic [PHY_W-1:0]        iss_rd_phy,
   output logic [31:0]             iss_inst_num
);

   localparam int IDX_W = $clog2(DEPTH);
   typedef rs_pkg::rs_entry_t ent_t;

   logic                   r_rst_sync;
   ent_t [DEPTH-1:0]       r_ent;
   ent_t [DEPTH-1:0]       w_ent_nxt;
   ent_t                   w_disp_ent;
   logic [DEPTH-1:0]       w_busy;
   logic [DEPTH-1:0]       w_elig;
   logic [DEPTH-1:0]       w_sel_oh;
   logic [DEPTH-1:0][31:0] w_inst_num;
   logic [IDX_W-1:0]       w_free_idx;
   logic [IDX_W-1:0]       w_sel_idx;
   logic                   w_sel_any;
   logic                   w_issue_en;
   logic                   w_dispatch;
   logic                   r_iss_valid;
   logic                   r_overflow;
   logic [DATA_W-1:0]      r_iss_pc, r_iss_op1, r_iss_op2, r_iss_imm;
   logic [3:0]             r_iss_aluop;
   logic                   r_iss_src1, r_iss_src2;
   logic [PHY_W-1:0]       r_iss_rd;
   logic [31:0]            r_iss_num;

   // Returns {valid, data}; lowest matching CDB port wins, tag 0 never wakes.
   function automatic logic [DATA_W:0] wake_op(
      input logic [PHY_W-1:0]        tag,
      input logic                    vld,
      input logic [DATA_W-1:0]       data,
      input logic [CDB_N-1:0]        cv,
      input logic [CDB_N*PHY_W-1:0]  cp,
      input logic [CDB_N*DATA_W-1:0] cd
   );
      logic [DATA_W:0] res;
      res = {vld, data};
      if (!vld && tag != '0) begin
         for (int p = CDB_N - 1; p >= 0; p--) begin
            if (cv[p] && cp[p*PHY_W +: PHY_W] == tag) begin
               res = {1'b1, cd[p*DATA_W +: DATA_W]};
            end
         end
      end
      return res;
   endfunction

   // Reset asserts asynchronously but releases on a clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_rst_sync <= 1'b0;
      else        r_rst_sync <= 1'b1;
   end

   // Per-entry status vectors and the lowest-index free slot.
   always_comb begin
      w_free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         w_busy[i]     = r_ent[i].busy;
         w_elig[i]     = r_ent[i].busy & r_ent[i].op1_valid & r_ent[i].op2_valid;
         w_inst_num[i] = r_ent[i].inst_num;
         if (!r_ent[i].busy) w_free_idx = IDX_W'(i);
         else                w_free_idx = w_free_idx;
      end
   end

   assign rs_full    = &w_busy;
   assign w_dispatch = add_rs_on & ~rs_full;
   assign w_issue_en = ~r_iss_valid | alu_ready;

   rs_oldest_select #(.DEPTH(DEPTH)) u_sel (
      .i_elig     (w_elig),
      .i_inst_num (w_inst_num),
      .o_onehot   (w_sel_oh),
      .o_idx      (w_sel_idx),
      .o_any      (w_sel_any)
   );

   // Build the incoming entry, including same-cycle CDB bypass.
   always_comb begin
      w_disp_ent          = '0;
      w_disp_ent.busy     = 1'b1;
      w_disp_ent.pc       = add_alu_pc;
      w_disp_ent.aluop    = out_add_ALUOP;
      w_disp_ent.src1     = out_add_ALUSrc1;
      w_disp_ent.src2     = out_add_ALUSrc2;
      w_disp_ent.rd_phy   = add_rd_phy_reg;
      w_disp_ent.op1_phy  = out_add_Operand1_phy;
      w_disp_ent.op2_phy  = out_add_Operand2_phy;
      w_disp_ent.imm      = out_add_immediate;
      w_disp_ent.inst_num = out_add_inst_num;
      {w_disp_ent.op1_valid, w_disp_ent.op1_data} = wake_op(out_add_Operand1_phy,
         out_add_valid[1] | (out_add_Operand1_phy == '0), disp_op1_data, cdb_valid, cdb_phy, cdb_data);
      {w_disp_ent.op2_valid, w_disp_ent.op2_data} = wake_op(out_add_Operand2_phy,
         out_add_valid[0] | (out_add_Operand2_phy == '0), disp_op2_data, cdb_valid, cdb_phy, cdb_data);
   end

   // Next entry state: wakeup, free on issue, dispatch write, then flush on top.
   always_comb begin
      w_ent_nxt = r_ent;
      for (int i = 0; i < DEPTH; i++) begin
         {w_ent_nxt[i].op1_valid, w_ent_nxt[i].op1_data} = wake_op(r_ent[i].op1_phy,
            r_ent[i].op1_valid, r_ent[i].op1_data, cdb_valid, cdb_phy, cdb_data);
         {w_ent_nxt[i].op2_valid, w_ent_nxt[i].op2_data} = wake_op(r_ent[i].op2_phy,
            r_ent[i].op2_valid, r_ent[i].op2_data, cdb_valid, cdb_phy, cdb_data);
         if (w_issue_en && w_sel_oh[i]) w_ent_nxt[i].busy = 1'b0;
         else                           w_ent_nxt[i].busy = r_ent[i].busy;
      end
      if (w_dispatch) w_ent_nxt[w_free_idx] = w_disp_ent;
      else            w_ent_nxt = w_ent_nxt;
      for (int i = 0; i < DEPTH; i++) begin
         if (flush) w_ent_nxt[i].busy = 1'b0;
         else       w_ent_nxt[i].busy = w_ent_nxt[i].busy;
      end
   end

   // Entry storage, sticky overflow flag and the issue register.
   always_ff @(posedge clk or negedge r_rst_sync) begin
      if (!r_rst_sync) begin
         r_ent       <= '0;
         r_overflow  <= 1'b0;
         r_iss_valid <= 1'b0;
         r_iss_pc    <= '0;
         r_iss_op1   <= '0;
         r_iss_op2   <= '0;
         r_iss_imm   <= '0;
         r_iss_aluop <= 4'h0;
         r_iss_src1  <= 1'b0;
         r_iss_src2  <= 1'b0;
         r_iss_rd    <= '0;
         r_iss_num   <= 32'h0;
      end else begin
         r_ent      <= w_ent_nxt;
         r_overflow <= r_overflow | (add_rs_on & rs_full);
         if (flush) begin
            r_iss_valid <= 1'b0;
         end else if (w_issue_en) begin
            r_iss_valid <= w_sel_any;
            if (w_sel_any) begin
               r_iss_pc    <= r_ent[w_sel_idx].pc;
               r_iss_op1   <= r_ent[w_sel_idx].op1_data;
               r_iss_op2   <= r_ent[w_sel_idx].op2_data;
               r_iss_imm   <= r_ent[w_sel_idx].imm;
               r_iss_aluop <= r_ent[w_sel_idx].aluop;
               r_iss_src1  <= r_ent[w_sel_idx].src1;
               r_iss_src2  <= r_ent[w_sel_idx].src2;
               r_iss_rd    <= r_ent[w_sel_idx].rd_phy;
               r_iss_num   <= r_ent[w_sel_idx].inst_num;
            end
         end
      end
   end

   assign rs_overflow  = r_overflow;
   assign iss_valid    = r_iss_valid;
   assign iss_pc       = r_iss_pc;
   assign iss_op1      = r_iss_op1;
   assign iss_op2      = r_iss_op2;
   assign iss_imm      = r_iss_imm;
   assign iss_aluop    = r_iss_aluop;
   assign iss_src1     = r_iss_src1;
   assign iss_src2     = r_iss_src2;
   assign iss_rd_phy   = r_iss_rd;
   assign iss_inst_num = r_iss_num;

endmodule
